// File: rtl/architecture_po_pulse_if.sv
// Avalon-MM slave bus bundle for the parallel output port.
interface architecture_po_pulse_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/architecture_po_pulse.sv
// Parallel output port with atomic set/clear and a one-shot bit-inversion pulse engine.
module architecture_po_pulse #(
  parameter int unsigned      WIDTH       = 4,
  parameter int unsigned      CNT_W       = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  architecture_po_pulse_if.slave  bus,
  output logic [WIDTH-1:0]        out_port
);

  localparam int unsigned BUS_W = 32;
  localparam int unsigned CLR_LSB = 16;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_LEN    = 2'd1;
  localparam logic [1:0] ADDR_PULSE  = 2'd2;
  localparam logic [1:0] ADDR_SETCLR = 2'd3;

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] pmask_q, pmask_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BUS_W-1:0] rd_c;

  logic             wr_c;
  logic [WIDTH-1:0] mask_c;
  logic [WIDTH-1:0] set_c;
  logic [WIDTH-1:0] clr_c;
  logic [CNT_W-1:0] len_eff_c;

  assign wr_c      = bus.chipselect & ~bus.write_n;
  assign mask_c    = bus.writedata[WIDTH-1:0];
  assign set_c     = bus.writedata[WIDTH-1:0];
  assign clr_c     = bus.writedata[CLR_LSB+WIDTH-1:CLR_LSB];
  // A programmed length of zero still produces a one-clock pulse.
  assign len_eff_c = (len_q == '0) ? CNT_W'(1) : len_q;

  // State and register file; async reset returns everything to idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      data_q       <= RESET_VALUE;
      pmask_q      <= '0;
      len_q        <= '0;
      cnt_q        <= '0;
      bus.readdata <= '0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      pmask_q      <= pmask_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      bus.readdata <= rd_c;
    end
  end

  // Next-state: data/len register writes plus the pulse countdown FSM.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    pmask_d = pmask_q;
    len_d   = len_q;
    cnt_d   = cnt_q;

    if (wr_c && bus.address == ADDR_DATA) begin
      data_d = bus.writedata[WIDTH-1:0];
    end
    if (wr_c && bus.address == ADDR_SETCLR) begin
      data_d = (data_q | set_c) & ~clr_c;
    end
    if (wr_c && bus.address == ADDR_LEN) begin
      len_d = bus.writedata[CNT_W-1:0];
    end

    unique case (state_q)
      IDLE: begin
        if (wr_c && bus.address == ADDR_PULSE && mask_c != '0) begin
          pmask_d = mask_c;
          cnt_d   = len_eff_c;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        // A zero mask aborts; a non-zero mask while running is ignored.
        if ((wr_c && bus.address == ADDR_PULSE && mask_c == '0) ||
            cnt_q == CNT_W'(1)) begin
          pmask_d = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Read mux: address-only decode, sampled into readdata every edge.
  always_comb begin
    rd_c = '0;
    unique case (bus.address)
      ADDR_DATA:   rd_c = BUS_W'(data_q);
      ADDR_LEN:    rd_c = BUS_W'(len_q);
      ADDR_PULSE:  rd_c = {state_q == ACTIVE, (BUS_W-1)'(pmask_q)};
      ADDR_SETCLR: rd_c = BUS_W'(cnt_q);
      default:     rd_c = '0;
    endcase
  end

  assign out_port = data_q ^ pmask_q;

endmodule
